// File: rtl/xb_pkg.sv
// Shared types for the wormhole-locking crossbar: flit type codes and per-output FSM states.
package xb_pkg;

  // Flit type lives in the two MSBs of every flit.
  typedef enum logic [1:0] {
    FtHead   = 2'b00,
    FtBody   = 2'b01,
    FtTail   = 2'b10,
    FtSingle = 2'b11
  } flit_type_e;

  localparam int unsigned FtWidth = 2;

  typedef enum logic {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } port_state_e;

  // Bit position of the flit-type MSB for a given flit width.
  function automatic int unsigned ft_msb(input int unsigned dw);
    return dw - 1;
  endfunction

endpackage

// File: rtl/xb_out_port.sv
// One crossbar output: picks a source by one-hot select or by the locked source,
// registers the flit, and tracks the HEAD..TAIL wormhole lock.
module xb_out_port
  import xb_pkg::*;
#(
  parameter int unsigned P  = 5,
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [P-1:0]    sel_i,
  input  logic [P*DW-1:0] data_i,
  input  logic [P-1:0]    valid_i,
  output logic [DW-1:0]   data_o,
  output logic            valid_o,
  output logic            lock_o,
  output logic            err_pulse_o
);

  localparam int unsigned SW    = $clog2(P);
  localparam int unsigned FtMsb = ft_msb(DW);

  port_state_e   state_q, state_d;
  logic [SW-1:0] src_q, src_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;

  logic [3:0]    sel_cnt;
  logic [SW-1:0] sel_idx;
  logic [DW-1:0] oh_data;
  logic          oh_valid;
  logic [DW-1:0] src_data;
  logic          src_valid;
  logic [DW-1:0] fwd_data;
  logic          fwd_valid;
  flit_type_e    fwd_type;
  logic          bad_sel;

  // AND-OR one-hot mux plus population count and index for the idle path.
  always_comb begin
    sel_cnt  = '0;
    sel_idx  = '0;
    oh_data  = '0;
    oh_valid = 1'b0;
    for (int i = 0; i < int'(P); i++) begin
      if (sel_i[i]) begin
        sel_cnt  = sel_cnt + 4'd1;
        sel_idx  = SW'(i);
        oh_data  = oh_data | data_i[i*DW +: DW];
        oh_valid = oh_valid | valid_i[i];
      end
    end
  end

  // Locked path: sel_i is ignored, the stored source drives the output.
  always_comb begin
    src_data  = data_i[int'(src_q)*DW +: DW];
    src_valid = valid_i[src_q];
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    bad_sel = 1'b0;
    if (state_q == StLocked) begin
      fwd_valid = src_valid;
      fwd_data  = src_data;
    end else begin
      fwd_valid = (sel_cnt == 4'd1) && oh_valid;
      fwd_data  = oh_data;
      bad_sel   = (sel_cnt > 4'd1);
    end
    fwd_type = flit_type_e'(fwd_data[FtMsb -: FtWidth]);
    valid_d  = fwd_valid;
    data_d   = fwd_valid ? fwd_data : data_q;

    if (fwd_valid) begin
      unique case (state_q)
        StIdle: begin
          if (fwd_type == FtHead) begin
            state_d = StLocked;
            src_d   = sel_idx;
          end
        end
        StLocked: begin
          if (fwd_type == FtTail) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      src_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign lock_o      = (state_q == StLocked);
  assign err_pulse_o = bad_sel;

endmodule

// File: rtl/xb_pipe_lock.sv
// P x P registered crossbar with per-output wormhole locks and a sticky
// error flag for malformed selects on idle outputs.
module xb_pipe_lock
  import xb_pkg::*;
#(
  parameter int unsigned P  = 5,
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [P*P-1:0]  sel_i,
  input  logic [P*DW-1:0] data_i,
  input  logic [P-1:0]    valid_i,
  input  logic            err_clr,
  output logic [P*DW-1:0] data_o,
  output logic [P-1:0]    valid_o,
  output logic [P-1:0]    lock_o,
  output logic            err_o
);

  logic [P-1:0] err_pulse;
  logic         err_q, err_d;

  for (genvar o = 0; o < int'(P); o++) begin : g_port
    xb_out_port #(
      .P  (P),
      .DW (DW)
    ) u_port (
      .clk         (clk),
      .rst         (rst),
      .sel_i       (sel_i[o*P +: P]),
      .data_i      (data_i),
      .valid_i     (valid_i),
      .data_o      (data_o[o*DW +: DW]),
      .valid_o     (valid_o[o]),
      .lock_o      (lock_o[o]),
      .err_pulse_o (err_pulse[o])
    );
  end

  // A fresh error outranks a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (|err_pulse) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule
